// File: rtl/am2911_pkg.sv
// Shared opcodes, slice source-select codes and decoder bundle types for am2911_ctl.
package am2911_pkg;

   // Am2910-style opcodes
   localparam logic [3:0] OP_JZ   = 4'd0;
   localparam logic [3:0] OP_CJS  = 4'd1;
   localparam logic [3:0] OP_JMAP = 4'd2;
   localparam logic [3:0] OP_CJP  = 4'd3;
   localparam logic [3:0] OP_PUSH = 4'd4;
   localparam logic [3:0] OP_JSRP = 4'd5;
   localparam logic [3:0] OP_CJV  = 4'd6;
   localparam logic [3:0] OP_JRP  = 4'd7;
   localparam logic [3:0] OP_RFCT = 4'd8;
   localparam logic [3:0] OP_RPCT = 4'd9;
   localparam logic [3:0] OP_CRTN = 4'd10;
   localparam logic [3:0] OP_CJPP = 4'd11;
   localparam logic [3:0] OP_LDCT = 4'd12;
   localparam logic [3:0] OP_LOOP = 4'd13;
   localparam logic [3:0] OP_CONT = 4'd14;
   localparam logic [3:0] OP_TWB  = 4'd15;

   // Slice source select
   localparam logic [1:0] S_UPC = 2'b00;
   localparam logic [1:0] S_AR  = 2'b01;
   localparam logic [1:0] S_STK = 2'b10;
   localparam logic [1:0] S_D   = 2'b11;

   // Lines driven to the am2911 slices and the d-bus sources
   typedef struct packed {
      logic [1:0] s;
      logic       fe_;
      logic       pup;
      logic       zero_;
      logic       re_;
      logic       cn;
      logic       pl_;
      logic       map_;
      logic       vect_;
   } ctl_t;

   // State-update strobes for the counter and depth tracker
   typedef struct packed {
      logic push;     // push driven to the slice
      logic pop;      // pop driven to the slice (not inhibited)
      logic pop_try;  // pop requested, regardless of depth
      logic load;     // cnt <= d
      logic dec;      // cnt <= cnt - 1
      logic clr_dep;  // depth <= 0
   } stb_t;

endpackage

// File: rtl/am2911_ctl_dec.sv
// Combinational instruction decoder: opcode/condition/counter state -> slice
// control lines and state-update strobes. Hold and reset overrides live here.
module am2911_ctl_dec
   import am2911_pkg::*;
(
   input  logic [3:0] i,
   input  logic       pass,
   input  logic       cnt_zero,
   input  logic       empty,
   input  logic       rld_,
   input  logic       hold,
   input  logic       rst,
   output ctl_t       ctl,
   output stb_t       stb
);

   logic [1:0] s_sel;
   logic       push_r, pop_r, ld_r, dec_r, clr_r;
   logic       zero_n, pl_n, map_n, vect_n;
   logic       active;

   // Raw opcode decode, before hold/reset/empty qualification
   always_comb begin
      s_sel  = S_UPC;
      push_r = 1'b0;
      pop_r  = 1'b0;
      ld_r   = 1'b0;
      dec_r  = 1'b0;
      clr_r  = 1'b0;
      zero_n = 1'b1;
      pl_n   = 1'b0;
      map_n  = 1'b1;
      vect_n = 1'b1;
      case (i)
         OP_JZ:   begin zero_n = 1'b0; clr_r = 1'b1; end
         OP_CJS:  if (pass) begin s_sel = S_D; push_r = 1'b1; end
         OP_JMAP: begin s_sel = S_D; map_n = 1'b0; pl_n = 1'b1; end
         OP_CJP:  if (pass) s_sel = S_D;
         OP_PUSH: begin push_r = 1'b1; ld_r = pass; end
         OP_JSRP: begin push_r = 1'b1; s_sel = pass ? S_D : S_AR; end
         OP_CJV:  begin
                     vect_n = 1'b0;
                     pl_n   = 1'b1;
                     if (pass) s_sel = S_D;
                  end
         OP_JRP:  s_sel = pass ? S_D : S_AR;
         OP_RFCT: if (!cnt_zero) begin s_sel = S_STK; dec_r = 1'b1; end
                  else pop_r = 1'b1;
         OP_RPCT: if (!cnt_zero) begin s_sel = S_D; dec_r = 1'b1; end
         OP_CRTN: if (pass) begin s_sel = S_STK; pop_r = 1'b1; end
         OP_CJPP: if (pass) begin s_sel = S_D; pop_r = 1'b1; end
         OP_LDCT: ld_r = 1'b1;
         OP_LOOP: if (!pass) s_sel = S_STK;
                  else pop_r = 1'b1;
         OP_TWB:  if (pass) pop_r = 1'b1;
                  else if (!cnt_zero) begin s_sel = S_STK; dec_r = 1'b1; end
                  else begin s_sel = S_D; pop_r = 1'b1; end
         default: ;
      endcase
   end

   assign active = ~hold & ~rst;

   // Qualify strobes and build the slice lines; a pop on an empty stack is
   // swallowed so the slice pointer stays aligned with the tracked depth
   always_comb begin
      stb.push    = active & push_r;
      stb.pop_try = active & pop_r;
      stb.pop     = active & pop_r & ~empty;
      stb.load    = active & (ld_r | ~rld_);
      stb.dec     = active & dec_r & ~(ld_r | ~rld_);
      stb.clr_dep = active & clr_r;

      ctl.s     = active ? s_sel : S_UPC;
      ctl.fe_   = ~(stb.push | stb.pop);
      ctl.pup   = stb.push;
      ctl.zero_ = rst ? 1'b0 : (hold ? 1'b1 : zero_n);
      ctl.re_   = ~stb.load;
      ctl.cn    = active;
      ctl.pl_   = pl_n;
      ctl.map_  = map_n;
      ctl.vect_ = vect_n;
   end

endmodule

// File: rtl/am2911_ctl.sv
// am2911 cascade controller: decoder plus loop counter and stack-depth tracker.
// Optional sticky stack error flags (ovf/unf) with macro AM2911_CTL_STKERR_EN.
module am2911_ctl
   import am2911_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             cp,
   input  logic             rst,
   input  logic [3:0]       i,
   input  logic             ccen_,
   input  logic             cc_,
   input  logic             rld_,
   input  logic             hold,
   input  logic [WIDTH-1:0] d,
   output logic [1:0]       s,
   output logic             fe_,
   output logic             pup,
   output logic             zero_,
   output logic             re_,
   output logic             cn,
   output logic             pl_,
   output logic             map_,
   output logic             vect_,
   output logic             full,
   output logic             empty,
   output logic             cnt_zero
`ifdef AM2911_CTL_STKERR_EN
   ,
   output logic             ovf,
   output logic             unf
`endif
);

   localparam int DW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] cnt;
   logic [DW-1:0]    dep;
   logic             pass;
   ctl_t             ctl;
   stb_t             stb;

   assign pass     = ccen_ | ~cc_;
   assign full     = (dep == DW'(DEPTH));
   assign empty    = (dep == '0);
   assign cnt_zero = (cnt == '0);

   am2911_ctl_dec u_dec (
      .i        (i),
      .pass     (pass),
      .cnt_zero (cnt_zero),
      .empty    (empty),
      .rld_     (rld_),
      .hold     (hold),
      .rst      (rst),
      .ctl      (ctl),
      .stb      (stb)
   );

   assign s     = ctl.s;
   assign fe_   = ctl.fe_;
   assign pup   = ctl.pup;
   assign zero_ = ctl.zero_;
   assign re_   = ctl.re_;
   assign cn    = ctl.cn;
   assign pl_   = ctl.pl_;
   assign map_  = ctl.map_;
   assign vect_ = ctl.vect_;

   // Loop counter: load from d wins over decrement; decoder never decrements 0
   always_ff @(posedge cp) begin
      if (rst)           cnt <= '0;
      else if (stb.load) cnt <= d;
      else if (stb.dec)  cnt <= cnt - WIDTH'(1);
   end

   // Tracked stack depth; saturates at DEPTH since the slice overwrites its oldest entry
   always_ff @(posedge cp) begin
      if (rst)                      dep <= '0;
      else if (stb.clr_dep)         dep <= '0;
      else if (stb.push && !full)   dep <= dep + DW'(1);
      else if (stb.pop)             dep <= dep - DW'(1);
   end

`ifdef AM2911_CTL_STKERR_EN
   // Sticky stack error flags, cleared only by reset
   always_ff @(posedge cp) begin
      if (rst) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (stb.push && full)     ovf <= 1'b1;
         if (stb.pop_try && empty) unf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_am2911_ctl.sv
// Self-checking bench for am2911_ctl: directed vector table plus randomized
// stimulus against a behavioural model of the sequencer rules.
module tb_am2911_ctl;
   import am2911_pkg::*;

   localparam int WIDTH = 12;
   localparam int DEPTH = 4;

   logic             cp = 1'b0;
   logic             rst, ccen_, cc_, rld_, hold;
   logic [3:0]       i;
   logic [WIDTH-1:0] d;
   logic [1:0]       s;
   logic             fe_, pup, zero_, re_, cn, pl_, map_, vect_;
   logic             full, empty, cnt_zero;
`ifdef AM2911_CTL_STKERR_EN
   logic             ovf, unf;
`endif

   am2911_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .cp(cp), .rst(rst), .i(i), .ccen_(ccen_), .cc_(cc_), .rld_(rld_),
      .hold(hold), .d(d), .s(s), .fe_(fe_), .pup(pup), .zero_(zero_),
      .re_(re_), .cn(cn), .pl_(pl_), .map_(map_), .vect_(vect_),
      .full(full), .empty(empty), .cnt_zero(cnt_zero)
`ifdef AM2911_CTL_STKERR_EN
      , .ovf(ovf), .unf(unf)
`endif
   );

   always #5 cp = ~cp;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rst, hold;
      logic [3:0]  i;
      logic        cc_, rld_;
      logic [11:0] d;
      logic [6:0]  ctl;    // {s, fe_, pup, zero_, re_, cn}
      logic [2:0]  flags;  // {full, empty, cnt_zero}
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, h, input logic [3:0] op, input logic c, rl,
                      input logic [11:0] dv, input logic [1:0] es,
                      input logic efe, epup, ez, ere, ecn, ef, ee, ecz);
      vec_t v;
      v.rst = r; v.hold = h; v.i = op; v.cc_ = c; v.rld_ = rl; v.d = dv;
      v.ctl = {es, efe, epup, ez, ere, ecn};
      v.flags = {ef, ee, ecz};
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, h, input logic [3:0] op,
                        input logic ce, c, rl, input logic [11:0] dv);
      @(negedge cp);
      rst = r; hold = h; i = op; ccen_ = ce; cc_ = c; rld_ = rl; d = dv;
      #2;
   endtask

   // Behavioural model state
   int m_cnt, m_dep;
   bit m_ovf, m_unf;

   // Expected lines for one cycle from the instruction rules, then advance model state
   task automatic ref_step(input logic r, h, input logic [3:0] op,
                           input logic ce, c, rl, input logic [11:0] dv,
                           output logic [9:0] e);
      bit p, go, wpush, wpop, lcnt, dcnt, jz, mp, vc, pl, push_ok, pop_ok, ld;
      logic [1:0] src;
      p = ce | ~c;
      go = !r && !h;
      src = S_UPC; wpush = 0; wpop = 0; lcnt = 0; dcnt = 0; jz = 0;
      mp = 1; vc = 1; pl = 0;
      case (op)
         OP_JZ:   jz = 1;
         OP_CJS:  if (p) begin src = S_D; wpush = 1; end
         OP_JMAP: begin src = S_D; mp = 0; pl = 1; end
         OP_CJP:  if (p) src = S_D;
         OP_PUSH: begin wpush = 1; lcnt = p; end
         OP_JSRP: begin wpush = 1; src = p ? S_D : S_AR; end
         OP_CJV:  begin vc = 0; pl = 1; if (p) src = S_D; end
         OP_JRP:  src = p ? S_D : S_AR;
         OP_RFCT: if (m_cnt != 0) begin src = S_STK; dcnt = 1; end else wpop = 1;
         OP_RPCT: if (m_cnt != 0) begin src = S_D; dcnt = 1; end
         OP_CRTN: if (p) begin src = S_STK; wpop = 1; end
         OP_CJPP: if (p) begin src = S_D; wpop = 1; end
         OP_LDCT: lcnt = 1;
         OP_LOOP: if (!p) src = S_STK; else wpop = 1;
         OP_TWB:  if (p) wpop = 1;
                  else if (m_cnt != 0) begin src = S_STK; dcnt = 1; end
                  else begin src = S_D; wpop = 1; end
         default: ;
      endcase
      push_ok = go && wpush;
      pop_ok  = go && wpop && (m_dep > 0);
      ld      = go && (lcnt || !rl);
      e = {go ? src : S_UPC, !(push_ok || pop_ok), push_ok,
           r ? 1'b0 : (h ? 1'b1 : !jz), !ld, go, pl, mp, vc};
      if (r) begin
         m_cnt = 0; m_dep = 0; m_ovf = 0; m_unf = 0;
      end else if (go) begin
         if (push_ok && m_dep == DEPTH) m_ovf = 1;
         if (wpop && m_dep == 0) m_unf = 1;
         if (ld) m_cnt = int'(dv);
         else if (dcnt) m_cnt = (m_cnt - 1) % (1 << WIDTH);
         if (jz) m_dep = 0;
         else if (push_ok) m_dep = (m_dep < DEPTH) ? m_dep + 1 : DEPTH;
         else if (pop_ok) m_dep = m_dep - 1;
      end
   endtask

   initial begin
      logic [9:0] e;
      logic       r, h, ce, c, rl;
      logic [3:0] op;
      logic [11:0] dv;

      rst = 1; hold = 0; i = OP_CONT; ccen_ = 0; cc_ = 1; rld_ = 1; d = '0;
      // Reset, then count up
      add(1,0,OP_CONT,1,1,12'h000, S_UPC,1,0,0,1,0, 0,1,1);
      add(0,0,OP_CONT,1,1,12'h000, S_UPC,1,0,1,1,1, 0,1,1);
      add(0,0,OP_CONT,1,1,12'h000, S_UPC,1,0,1,1,1, 0,1,1);
      // LDCT 3, RPCT jumps three times then falls through
      add(0,0,OP_LDCT,1,1,12'h003, S_UPC,1,0,1,0,1, 0,1,1);
      for (int k = 0; k < 3; k++)
         add(0,0,OP_RPCT,1,1,12'h010, S_D,1,0,1,1,1, 0,1,0);
      add(0,0,OP_RPCT,1,1,12'h010, S_UPC,1,0,1,1,1, 0,1,1);
      // CJS then CRTN
      add(0,0,OP_CJS,0,1,12'h040, S_D,0,1,1,1,1, 0,1,1);
      add(0,0,OP_CRTN,0,1,12'h000, S_STK,0,0,1,1,1, 0,0,1);
      // Five pushes: saturate at DEPTH
      for (int k = 0; k < 5; k++)
         add(0,0,OP_PUSH,1,1,12'h123, S_UPC,0,1,1,1,1, k >= 4, k == 0, 1);
      // Five returns: the fifth is inhibited on the empty stack
      for (int k = 0; k < 4; k++)
         add(0,0,OP_CRTN,0,1,12'h000, S_STK,0,0,1,1,1, k == 0, 0, 1);
      add(0,0,OP_CRTN,0,1,12'h000, S_STK,1,0,1,1,1, 0,1,1);
      // TWB failing: loop twice, then exit to d with pop
      add(0,0,OP_LDCT,1,1,12'h002, S_UPC,1,0,1,0,1, 0,1,1);
      add(0,0,OP_PUSH,1,1,12'h000, S_UPC,0,1,1,1,1, 0,1,0);
      add(0,0,OP_TWB,1,1,12'h077, S_STK,1,0,1,1,1, 0,0,0);
      add(0,0,OP_TWB,1,1,12'h077, S_STK,1,0,1,1,1, 0,0,0);
      add(0,0,OP_TWB,1,1,12'h077, S_D,0,0,1,1,1, 0,0,1);
      // TWB passing: pop and continue
      add(0,0,OP_PUSH,1,1,12'h000, S_UPC,0,1,1,1,1, 0,1,1);
      add(0,0,OP_TWB,0,1,12'h077, S_UPC,0,0,1,1,1, 0,0,1);
      // Hold during RFCT keeps cnt=4, then four decrements, then inhibited pop
      add(0,0,OP_LDCT,1,1,12'h004, S_UPC,1,0,1,0,1, 0,1,1);
      add(0,1,OP_RFCT,1,1,12'h000, S_UPC,1,0,1,1,0, 0,1,0);
      for (int k = 0; k < 4; k++)
         add(0,0,OP_RFCT,1,1,12'h000, S_STK,1,0,1,1,1, 0,1,0);
      add(0,0,OP_RFCT,1,1,12'h000, S_UPC,1,0,1,1,1, 0,1,1);
      // JZ, then rld_ forced load during CONT
      add(0,0,OP_JZ,1,1,12'h000, S_UPC,1,0,0,1,1, 0,1,1);
      add(0,0,OP_CONT,1,0,12'h005, S_UPC,1,0,1,0,1, 0,1,1);
      add(0,0,OP_CONT,1,1,12'h000, S_UPC,1,0,1,1,1, 0,1,0);

      // Put the design into a known state before the table
      drive(1,0,OP_CONT,0,1,1,12'h000);

      foreach (tbl[n]) begin
         drive(tbl[n].rst, tbl[n].hold, tbl[n].i, 1'b0, tbl[n].cc_, tbl[n].rld_, tbl[n].d);
         chk($sformatf("vec%0d ctl", n), 32'({s, fe_, pup, zero_, re_, cn}), 32'(tbl[n].ctl));
         chk($sformatf("vec%0d flags", n), 32'({full, empty, cnt_zero}), 32'(tbl[n].flags));
      end
`ifdef AM2911_CTL_STKERR_EN
      // Both sticky errors were provoked above and must persist
      chk("sticky ovf", 32'(ovf), 32'd1);
      chk("sticky unf", 32'(unf), 32'd1);
      drive(1,0,OP_CONT,0,1,1,12'h000);
      drive(0,0,OP_CONT,0,1,1,12'h000);
      chk("err clear", 32'({ovf, unf}), 32'd0);
`endif

      // Randomized run against the behavioural model
      drive(1,0,OP_CONT,0,1,1,12'h000);
      ref_step(1,0,OP_CONT,0,1,1,12'h000, e);
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(0, 63) == 0);
         h  = ($urandom_range(0, 7) == 0);
         op = 4'($urandom_range(0, 15));
         ce = ($urandom_range(0, 3) == 0);
         c  = 1'($urandom);
         rl = ($urandom_range(0, 7) != 0);
         dv = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 3)) : 12'($urandom);
         drive(r, h, op, ce, c, rl, dv);
         chk("rnd flags", 32'({full, empty, cnt_zero}),
             32'({m_dep == DEPTH, m_dep == 0, m_cnt == 0}));
`ifdef AM2911_CTL_STKERR_EN
         chk("rnd err", 32'({ovf, unf}), 32'({m_ovf, m_unf}));
`endif
         ref_step(r, h, op, ce, c, rl, dv, e);
         chk("rnd ctl", 32'({s, fe_, pup, zero_, re_, cn, pl_, map_, vect_}), 32'(e));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/am2911_ctl.md
Name: am2911_ctl

Overview:
- Microprogram controller for a cascade of am2911 sequencer slices.
- Decodes a 4-bit Am2910-style instruction and a condition code into the slice control lines: s, fe_, pup, zero_, re_, cn.
- Adds the features the am2911 lacks: a loop register/counter, stack-depth tracking with full/empty flags, and a hold input.
- Sits between the pipeline register and the am2911 slices.

Parameters:
- WIDTH, 12: address/counter width; equals 4 × number of slices.
- DEPTH, 4: am2911 stack depth in entries.

Ports:
- cp  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- i  input  4  microinstruction opcode.
- ccen_  input  1  condition enable, active-low.
- cc_  input  1  condition code, active-low.
- rld_  input  1  force load of counter and slice AR from d, active-low.
- hold  input  1  freeze the sequencer for this cycle.
- d  input  WIDTH  branch/count data; same bus as the slice din.
- s  output  2  slice source select: 00 uPC, 01 AR, 10 STK0, 11 D.
- fe_  output  1  slice file enable, active-low.
- pup  output  1  slice push (1) / pop (0).
- zero_  output  1  slice zero, active-low.
- re_  output  1  slice AR load enable, active-low.
- cn  output  1  slice uPC increment carry.
- pl_, map_, vect_  output  1 each  source enables for the d bus, active-low.
- full  output  1  tracked depth == DEPTH.
- empty  output  1  tracked depth == 0.
- cnt_zero  output  1  counter == 0.

Behaviour:
- pass = ccen_ | ~cc_.
- All outputs are combinational from i, pass, hold and registered state. State is cnt[WIDTH], dep[0..DEPTH].
- Default drive: s=00, fe_=1, pup=x→0, zero_=1, re_=rld_, cn=1, pl_=0, map_=1, vect_=1.
- push: fe_=0, pup=1. pop: fe_=0, pup=0.
- Opcodes (ops not listed use the defaults):
  - 0 JZ: zero_=0; dep<=0.
  - 1 CJS: pass → s=11, push.
  - 2 JMAP: s=11, map_=0, pl_=1.
  - 3 CJP: pass → s=11.
  - 4 PUSH: push; pass → cnt<=d, re_=0.
  - 5 JSRP: push; s = pass ? 11 : 01.
  - 6 CJV: vect_=0, pl_=1; pass → s=11.
  - 7 JRP: s = pass ? 11 : 01.
  - 8 RFCT: cnt≠0 → s=10, cnt<=cnt−1; else pop.
  - 9 RPCT: cnt≠0 → s=11, cnt<=cnt−1.
  - 10 CRTN: pass → s=10, pop.
  - 11 CJPP: pass → s=11, pop.
  - 12 LDCT: cnt<=d, re_=0.
  - 13 LOOP: fail → s=10; pass → pop.
  - 14 CONT: defaults.
  - 15 TWB: fail & cnt≠0 → s=10, cnt<=cnt−1; fail & cnt=0 → s=11, pop; pass → pop.
- Counter and AR loads: rld_=0 loads cnt<=d in any instruction and overrides decrement.
- Depth tracking:
  - push: dep<=dep+1, saturating at DEPTH. The slice wraps and overwrites the oldest entry; the push is still driven.
  - pop with dep=0: inhibited (fe_=1, dep unchanged); the slice stack pointer stays aligned.
  - Otherwise pop: dep<=dep−1.
- hold=1 overrides all decoding: s=00, cn=0, fe_=1, re_=1, zero_=1. cnt and dep unchanged. The slice re-issues the same address.
- rst=1 (synchronous): next edge sets cnt=0, dep=0, flags=0. While rst is asserted: zero_=0, fe_=1, re_=1, cn=0, so the slice output is 0 and the slice uPC loads 0.
- Reset applied mid-loop abandons the loop; no partial counter update.
- cnt arithmetic is modulo 2^WIDTH. Decrement happens only when cnt≠0, so there is no underflow.

Optional Feature:
- Macro AM2911_CTL_STKERR_EN.
- Defined:
  - Adds outputs ovf and unf, registered and sticky.
  - ovf sets when a push occurs with full=1.
  - unf sets when a pop is attempted with empty=1.
  - Both are cleared only by rst.
- Undefined: ports absent, no extra registers; all other behaviour identical.

Decomposition:
- Package am2911_pkg:
  - opcode localparams (JZ…TWB);
  - s-select encodings (S_UPC=2'b00, S_AR=2'b01, S_STK=2'b10, S_D=2'b11).
- One natural sub-module: am2911_ctl_dec, the pure combinational decoder (i, pass, cnt_zero, hold → control lines, push/pop/load/dec strobes). Counter, depth and flags stay in am2911_ctl.
- Bench instantiates am2911_ctl with 3 am2911 slices (WIDTH=12).

Test Plan:
- Reset: rst=1 for 2 cycles → y=000, dep=0, empty=1, cnt_zero=1. Release with i=CONT → y increments 001, 002.
- CJS then CRTN: at uPC=005, CJS d=040 pass → y=040, dep=1, STK0=006. CRTN pass → y=006, dep=0.
- RPCT: LDCT d=003 → cnt=3. Then RPCT d=010 repeated → three jumps to 010 (cnt 2,1,0), fourth falls through to uPC+1.
- Depth: 5× PUSH → full=1 after the 4th, dep stays 4, ovf=1 (with macro). Then 5× CRTN pass → 5th has fe_=1, empty=1, unf=1.
- TWB: cnt=2, cc_=1 → loops to STK0 twice. Next cycle → s=11, y=d, pop. Repeat with cc_=0 → pop, y=uPC+1.
- hold=1 during RFCT with cnt=4 → y unchanged, cnt stays 4, dep unchanged. Release → cnt=3.
